mac_pipe_tile: RTL
==================

Name: mac_pipe_tile

Overview:
- Pipelined, configurable multiply-accumulate tile for the MAC column of the fabric; successor to the purely combinational MAC tile.
- Takes LANES operand pairs per cycle and forms their dot product.
- Either emits that dot product every sample, or accumulates a configured number of samples before emitting.
- Adds an optional input register, signed/unsigned arithmetic, an output shift, and saturation with an overflow flag. Configuration is latched by `cset`, as elsewhere in the fabric.

Parameters:
- WW, 4: operand word width (bits).
- LANES, 2: parallel multiplier lanes.
- OW, 2*WW: output data width.
- ACCW, 2*WW+$clog2(LANES)+8: accumulator width (includes 8 guard bits).
- LW, 8: accumulate-length field width.
- SHW, $clog2(ACCW): shift-amount field width (derived).
- CONFW, 4+SHW+LW: configuration word width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cset  in  1  configuration latch strobe
- conf  in  CONFW  configuration word, sampled when cset=1
- in_valid  in  1  operand sample valid
- in_clear  in  1  discard partial accumulation
- in_a  in  LANES*WW  operand A, lane k at [k*WW +: WW]
- in_b  in  LANES*WW  operand B, same lane layout
- out_valid  out  1  result valid (one-cycle pulse per result)
- out_data  out  OW  result
- out_ovf  out  1  result clipped or wrapped; qualified by out_valid

Behaviour:
- Clock and reset
  - Single clock `clk`. Reset `rst` is synchronous, active-high.
  - On rst: config register=0, all pipeline valid/clear flags=0, accumulator=0, sample counter=0, out_valid=0, out_data=0, out_ovf=0.
- Config register layout
  - [0] sgn: signed two's-complement operands.
  - [1] inreg: insert an input register stage.
  - [2] sat: saturate output; otherwise wrap.
  - [3] mode: 0=per-sample, 1=accumulate.
  - [4 +: SHW] shift: arithmetic right shift if sgn, logical otherwise.
  - [4+SHW +: LW] len: accumulate len+1 samples.
- cset=1 (rst has priority)
  - Latch conf and flush all valid/clear flags, accumulator and counter in the same cycle.
  - Inputs presented in that cycle are dropped. out_valid=0 next cycle.
- Pipeline (no backpressure; one sample per cycle accepted)
  - S0, present only if inreg=1: registers in_valid, in_clear, in_a, in_b.
  - S1: registers LANES products, each 2*WW bits, sign- or zero-extended per sgn; also registers the valid and clear flags.
  - S2: adder tree sums the products into ACCW bits, then updates the accumulator and registers the output.
- Latency: a sample presented in cycle t produces out_valid in cycle t+2 (inreg=0) or t+3 (inreg=1). The same latency applies to the final sample of an accumulation.
- Mode 0
  - Every valid sample: result = sum of products; accumulator unused.
  - len and in_clear are ignored.
- Mode 1
  - Counter counts accepted samples.
  - For the first sample (counter=0): acc_next=sum. Otherwise acc_next=acc+sum, wrapping mod 2^ACCW.
  - When counter==len: emit result from acc_next, reset counter to 0, next sample starts fresh. So len=0 emits every sample.
- in_clear
  - Travels with its cycle through the pipeline, with or without in_valid.
  - At S2 it zeroes the counter before that cycle's sample is applied. A simultaneous valid sample therefore becomes the first of a new accumulation.
  - No output is produced for the discarded partial.
- Output formatting
  - v = result >> shift.
  - If v fits in OW bits (signed range if sgn, unsigned otherwise): out_data=v, out_ovf=0.
  - Otherwise out_ovf=1, and out_data = the range max/min if sat=1, or the low OW bits if sat=0.
- Invalid-cycle outputs: out_data and out_ovf hold their last values while out_valid=0.
- Reconfiguration mid-accumulation: cset discards the partial result and emits no output.

Test Plan:
- Per-sample, unsigned, inreg=0, shift=0 (WW=4, LANES=2, OW=8): a={3,2}, b={5,4} at cycle t → out_valid=1 at t+2 only, out_data=23, out_ovf=0. Repeat with inreg=1 → result at t+3.
- Signed: lane0 a=0xD (−3), b=7; lane1 a=0 → out_data=0xEB (−21), out_ovf=0. Same operands with sgn=0 → out_data=91.
- Accumulate, len=3: eight consecutive samples each summing to 10 → exactly two out_valid pulses, each 40, on the 4th and 8th samples' output cycles; no pulses in between.
- Overflow, signed, len=3: four samples of a={7,7}, b={7,7} (sum 98 each, total 392)
  - sat=1 → out_data=127, out_ovf=1.
  - sat=0 → out_data=0x88, out_ovf=1.
  - shift=2 with sat=1 → 98 → out_data=98, out_ovf=0.
- Clear and flush
  - in_clear together with the 3rd sample of a len=3 run → output appears after 3 further samples (4 total from the clear), with the pre-clear samples excluded.
  - cset asserted mid-run → no output from the partial; the new config takes effect from the next cycle.
  - rst mid-run → all outputs 0 next cycle.

Source files
------------

// File: rtl/mac_pipe_tile.sv
// mac_pipe_tile: pipelined multiply-accumulate tile for the MAC column.
// Forms the dot product of LANES operand pairs per cycle. It either emits every
// dot product or accumulates len+1 samples before emitting. The result is
// shifted right, then saturated or wrapped to OW bits.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   cset       configuration latch strobe; flushes the pipeline
//   conf       configuration word {len, shift, mode, sat, inreg, sgn}
//   in_valid   operand sample valid
//   in_clear   discard partial accumulation (travels with its cycle)
//   in_a/in_b  operands, lane k at [k*WW +: WW]
//   out_valid  one-cycle result pulse
//   out_data   formatted result (held while out_valid=0)
//   out_ovf    result clipped or wrapped
module mac_pipe_tile #(
  parameter int unsigned WW    = 4,
  parameter int unsigned LANES = 2,
  parameter int unsigned OW    = 2 * WW,
  parameter int unsigned ACCW  = 2 * WW + $clog2(LANES) + 8,
  parameter int unsigned LW    = 8,
  parameter int unsigned SHW   = $clog2(ACCW),
  parameter int unsigned CONFW = 4 + SHW + LW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cset,
  input  logic [CONFW-1:0]    conf,
  input  logic                in_valid,
  input  logic                in_clear,
  input  logic [LANES*WW-1:0] in_a,
  input  logic [LANES*WW-1:0] in_b,
  output logic                out_valid,
  output logic [OW-1:0]       out_data,
  output logic                out_ovf
);

  logic [CONFW-1:0] cfg_q;
  logic             cfg_sgn, cfg_inreg, cfg_sat, cfg_mode;
  logic [SHW-1:0]   cfg_shift;
  logic [LW-1:0]    cfg_len;

  assign cfg_sgn   = cfg_q[0];
  assign cfg_inreg = cfg_q[1];
  assign cfg_sat   = cfg_q[2];
  assign cfg_mode  = cfg_q[3];
  assign cfg_shift = cfg_q[4 +: SHW];
  assign cfg_len   = cfg_q[4 + SHW +: LW];

  // S0 optional input register
  logic                s0_valid_q, s0_clear_q;
  logic [LANES*WW-1:0] s0_a_q, s0_b_q;

  logic                st_valid, st_clear;
  logic [LANES*WW-1:0] st_a, st_b;

  always_comb begin
    st_valid = cfg_inreg ? s0_valid_q : in_valid;
    st_clear = cfg_inreg ? s0_clear_q : in_clear;
    st_a     = cfg_inreg ? s0_a_q : in_a;
    st_b     = cfg_inreg ? s0_b_q : in_b;
  end

  // S1 products. Extending operands to 2*WW first keeps the low 2*WW product
  // bits exact for both signed and unsigned operands.
  logic [2*WW-1:0]             op_a, op_b;
  logic [LANES-1:0][2*WW-1:0]  prod_d, prod_q;
  logic                        s1_valid_q, s1_clear_q;

  always_comb begin
    op_a   = '0;
    op_b   = '0;
    prod_d = '0;
    for (int k = 0; k < LANES; k++) begin
      op_a      = {{WW{cfg_sgn & st_a[k*WW+WW-1]}}, st_a[k*WW +: WW]};
      op_b      = {{WW{cfg_sgn & st_b[k*WW+WW-1]}}, st_b[k*WW +: WW]};
      prod_d[k] = op_a * op_b;
    end
  end

  // S2 adder tree, accumulator and output formatting
  logic [ACCW-1:0] sum;

  always_comb begin
    sum = '0;
    for (int k = 0; k < LANES; k++) begin
      sum = sum + {{(ACCW-2*WW){cfg_sgn & prod_q[k][2*WW-1]}}, prod_q[k]};
    end
  end

  logic [ACCW-1:0] acc_q, acc_d, acc_next, result;
  logic [LW-1:0]   cnt_q, cnt_d, cnt_eff;
  logic            emit;

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    emit     = 1'b0;
    result   = sum;
    // A clear restarts the count before this cycle's sample is applied.
    cnt_eff  = s1_clear_q ? '0 : cnt_q;
    acc_next = (cnt_eff == '0) ? sum : acc_q + sum;
    if (!cfg_mode) begin
      emit = s1_valid_q;
    end else begin
      cnt_d = cnt_eff;
      if (s1_valid_q) begin
        result = acc_next;
        if (cnt_eff == cfg_len) begin
          emit  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_eff + LW'(1);
          acc_d = acc_next;
        end
      end
    end
  end

  logic [ACCW-1:0] shifted;
  logic [OW-1:0]   sat_val, fmt_data;
  logic            fits, fmt_ovf;

  always_comb begin
    if (cfg_sgn) begin
      shifted = $signed(result) >>> cfg_shift;
      fits    = shifted[ACCW-1:OW-1] == {(ACCW-OW+1){shifted[ACCW-1]}};
      sat_val = shifted[ACCW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end else begin
      shifted = result >> cfg_shift;
      fits    = shifted[ACCW-1:OW] == '0;
      sat_val = '1;
    end
    fmt_ovf  = ~fits;
    fmt_data = (fits || !cfg_sat) ? shifted[OW-1:0] : sat_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q      <= '0;
      s0_valid_q <= 1'b0;
      s0_clear_q <= 1'b0;
      s0_a_q     <= '0;
      s0_b_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_clear_q <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ovf    <= 1'b0;
    end else if (cset) begin
      // New config: drop this cycle's inputs and everything in flight.
      cfg_q      <= conf;
      s0_valid_q <= 1'b0;
      s0_clear_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_clear_q <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_valid  <= 1'b0;
    end else begin
      s0_valid_q <= in_valid;
      s0_clear_q <= in_clear;
      s0_a_q     <= in_a;
      s0_b_q     <= in_b;
      s1_valid_q <= st_valid;
      s1_clear_q <= st_clear;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_valid  <= emit;
      if (emit) begin
        out_data <= fmt_data;
        out_ovf  <= fmt_ovf;
      end
    end
  end

endmodule
